pkt_crc_rx: RTL and testbench
=============================

// Module: pkt_crc_rx
// PURPOSE
//  Host-link frame receiver feeding the miner command path. Parses the UART byte stream
//  [SOF 0xA5][LEN][payload x LEN][CRC32 x4, LSB first] and checks CRC-32 over the payload
//  (reflected 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF). It buffers the payload and
//  releases it downstream only when the CRC matches; bad or oversized frames are dropped and flagged.
// PARAMETERS
//  MAX_LEN         64    max payload bytes (1..255); sets buffer depth
//  TIMEOUT_CYCLES  1000  inter-byte idle limit, used only with PKT_RX_TIMEOUT_EN
// PORTS
//  i_clk        in   1   clock
//  i_rst        in   1   synchronous reset, active-high
//  i_valid      in   1   input byte valid
//  i_data       in   8   input byte
//  o_ready      out  1   receiver accepts i_data this cycle
//  o_valid      out  1   payload byte valid
//  o_data       out  8   payload byte
//  o_last       out  1   final payload byte of frame
//  i_ready      in   1   downstream accepts o_data
//  o_frame_ok   out  1   1-cycle pulse: frame passed CRC; drain begins next cycle
//  o_crc_err    out  1   1-cycle pulse: CRC mismatch, frame dropped
//  o_len_err    out  1   1-cycle pulse: LEN==0 or LEN>MAX_LEN
//  o_timeout    out  1   1-cycle pulse: inter-byte timeout (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state HUNT, all counters 0, crc=0xFFFFFFFF, o_valid/o_last/pulses 0, o_ready 1.
//  - Input handshake: byte consumed when i_valid&&o_ready. o_ready=1 in HUNT/LEN/PAYLOAD/CRC, 0 in DRAIN.
//  - FSM, transitions on consumed bytes:
//    HUNT: 0xA5 -> LEN; other bytes discarded silently.
//    LEN: 1..MAX_LEN -> latch len, crc=0xFFFFFFFF, wr_ptr=0 -> PAYLOAD; else o_len_err, -> HUNT.
//    PAYLOAD: write buf[wr_ptr], crc=upd(crc,byte), wr_ptr++; after byte len-1 -> CRC.
//    CRC: shift 4 bytes into rx_crc, LSB first; on 4th byte compare rx_crc with crc^0xFFFFFFFF.
//         Match -> o_frame_ok, -> DRAIN. Mismatch -> o_crc_err, -> HUNT.
//    DRAIN: o_valid=1, o_data=buf[rd_ptr]. Advance on i_ready. o_last=1 when rd_ptr==len-1;
//           accepting that byte -> HUNT, rd_ptr=0.
//  - A 0xA5 byte inside LEN/PAYLOAD/CRC is data. No resync on SOF mid-frame.
//  - Latency: o_frame_ok fires in the cycle after the 4th CRC byte is consumed. First o_valid
//    coincides with o_frame_ok+1. o_data is registered, with no bubble between beats when i_ready=1.
//  - o_data/o_last are stable while o_valid&&!i_ready.
//  - Reset mid-frame or mid-drain: return to reset state immediately. Partial frame lost, no pulse.
//  - The buffer holds exactly one frame, so a new frame cannot start until the drain completes.
// CONFIGURATION
//  PKT_RX_TIMEOUT_EN defined: an idle counter clears on every consumed byte and counts in
//    LEN/PAYLOAD/CRC. Reaching TIMEOUT_CYCLES -> o_timeout pulse, -> HUNT. It does not count in HUNT/DRAIN.
//  Not defined: no counter. o_timeout is tied 0, and a stalled frame waits forever.
// STRUCTURE
//  pkt_rx_pkg: SOF_BYTE=8'hA5, CRC_INIT=32'hFFFFFFFF, CRC_XOR=32'hFFFFFFFF, state enum
//    rx_state_t {HUNT,LEN,PAYLOAD,CRC,DRAIN}.
//  Sub-module: instantiate the team's existing crc_func (combinational byte update) for upd().
//  Payload buffer: inferred single-port-write / registered-read RAM, depth MAX_LEN.
// TESTING
//  1 A5 09 "123456789" 26 39 F4 CB -> o_frame_ok once; out 31..39, o_last on 0x39.
//  2 Same frame with last CRC byte CA -> o_crc_err once; o_valid never asserts; next good frame passes.
//  3 LEN=00, then LEN=MAX_LEN+1 -> o_len_err each time; back in HUNT; following good frame passes.
//  4 Test 1 with i_ready toggling 1-0-1 randomly -> o_ready=0 during DRAIN; 9 bytes in order, none dropped.
//  5 Garbage 00 FF 12, then test 1 frame back-to-back with another valid frame (LEN=1, payload A5)
//    -> both delivered; the A5 payload is output as data.
//  6 (PKT_RX_TIMEOUT_EN) Stop after 3 payload bytes for TIMEOUT_CYCLES -> o_timeout, HUNT;
//    i_rst mid-PAYLOAD -> no pulses, next frame passes.

Source files
------------

// File: rtl/pkt_rx_pkg.sv
// Shared constants and FSM state type for the host-link frame receiver.
package pkt_rx_pkg;

  localparam logic [7:0]  SOF_BYTE     = 8'hA5;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOR      = 32'hFFFFFFFF;
  // Bit-reversed form of 0x04C11DB7 for the LSB-first CRC-32.
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB88320;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CRC,
    DRAIN
  } rx_state_t;

endpackage

// File: rtl/pkt_crc_rx_crc_func.sv
// crc_func: combinational one-byte update of a reflected CRC-32 register.
module crc_func
  import pkt_rx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY_REF) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/pkt_crc_rx.sv
// pkt_crc_rx: SOF/LEN/payload/CRC-32 frame receiver with a one-frame payload buffer.
// Optional inter-byte timeout is enabled by defining PKT_RX_TIMEOUT_EN.
module pkt_crc_rx
  import pkt_rx_pkg::*;
#(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_valid,
  input  logic [7:0] i_data,
  output logic      o_ready,
  output logic      o_valid,
  output logic [7:0] o_data,
  output logic      o_last,
  input  logic      i_ready,
  output logic      o_frame_ok,
  output logic      o_crc_err,
  output logic      o_len_err,
  output logic      o_timeout,
  output rx_state_t o_state
);

  localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // valid never depends on ready, and data/last hold while valid && !ready.
  rx_state_t   state;
  logic [7:0]  len;
  logic [7:0]  wr_ptr;
  logic [7:0]  rd_ptr;
  logic [31:0] crc;
  logic [31:0] rx_crc;
  logic [1:0]  crc_cnt;
  logic [31:0] crc_next;
  logic [31:0] rx_crc_full;
  logic        take;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  mem [MAX_LEN];

  assign o_ready     = (state != DRAIN);
  assign o_state     = state;
  assign take        = i_valid && o_ready;
  assign wr_en       = take && (state == PAYLOAD);
  assign rx_crc_full = {i_data, rx_crc[31:8]};
  // Fetch the next beat whenever the output register is empty or being consumed,
  // unless the beat in it is already the last one.
  assign rd_en       = (state == DRAIN) && (!o_valid || i_ready) && !(o_valid && o_last);

  crc_func u_crc (
    .crc      (crc),
    .data     (i_data),
    .crc_next (crc_next)
  );

  // Payload RAM: single write port, registered read straight into o_data.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= i_data;
    if (rd_en) o_data <= mem[rd_ptr[AW-1:0]];
  end

`ifdef PKT_RX_TIMEOUT_EN
  logic [31:0] idle_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= HUNT;
      len        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      crc        <= CRC_INIT;
      rx_crc     <= '0;
      crc_cnt    <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_frame_ok <= 1'b0;
      o_crc_err  <= 1'b0;
      o_len_err  <= 1'b0;
`ifdef PKT_RX_TIMEOUT_EN
      o_timeout  <= 1'b0;
      idle_cnt   <= '0;
`endif
    end else begin
      o_frame_ok <= 1'b0;
      o_crc_err  <= 1'b0;
      o_len_err  <= 1'b0;
`ifdef PKT_RX_TIMEOUT_EN
      o_timeout  <= 1'b0;
`endif
      case (state)
        HUNT: begin
          if (take && i_data == SOF_BYTE) state <= LEN;
        end
        LEN: begin
          if (take) begin
            if (i_data != 8'd0 && i_data <= MAX_LEN8) begin
              len    <= i_data;
              crc    <= CRC_INIT;
              wr_ptr <= '0;
              state  <= PAYLOAD;
            end else begin
              o_len_err <= 1'b1;
              state     <= HUNT;
            end
          end
        end
        PAYLOAD: begin
          if (take) begin
            crc    <= crc_next;
            wr_ptr <= wr_ptr + 8'd1;
            if (wr_ptr == len - 8'd1) begin
              crc_cnt <= '0;
              state   <= CRC;
            end
          end
        end
        CRC: begin
          if (take) begin
            rx_crc  <= rx_crc_full;
            crc_cnt <= crc_cnt + 2'd1;
            if (crc_cnt == 2'd3) begin
              if (rx_crc_full == (crc ^ CRC_XOR)) begin
                o_frame_ok <= 1'b1;
                rd_ptr     <= '0;
                state      <= DRAIN;
              end else begin
                o_crc_err <= 1'b1;
                state     <= HUNT;
              end
            end
          end
        end
        DRAIN: begin
          if (rd_en) begin
            o_valid <= 1'b1;
            o_last  <= (rd_ptr == len - 8'd1);
            rd_ptr  <= rd_ptr + 8'd1;
          end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            rd_ptr  <= '0;
            state   <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
`ifdef PKT_RX_TIMEOUT_EN
      // Idle time only matters while a frame is partially received.
      if (take || state == HUNT || state == DRAIN) begin
        idle_cnt <= '0;
      end else if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        idle_cnt  <= '0;
        o_timeout <= 1'b1;
        state     <= HUNT;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pkt_crc_rx.sv
// Randomized self-checking bench for pkt_crc_rx with a frame-level reference model.
module tb_pkt_crc_rx;
  import pkt_rx_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int TO      = 40;
  localparam int BUDGET  = 5000;

  logic      clk, rst;
  logic      i_valid, i_ready;
  logic [7:0] i_data;
  logic      o_ready, o_valid, o_last;
  logic [7:0] o_data;
  logic      o_frame_ok, o_crc_err, o_len_err, o_timeout;
  rx_state_t o_state;

  pkt_crc_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready),
    .o_frame_ok(o_frame_ok), .o_crc_err(o_crc_err), .o_len_err(o_len_err),
    .o_timeout(o_timeout), .o_state(o_state)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] pl_q[$];
  int  n_ok = 0, n_crc = 0, n_len = 0, n_to = 0;
  int  lat_viol = 0, stab_viol = 0, rdy_viol = 0;
  bit  rnd_ready = 0;
  bit  hold_v = 0, prev_ok = 0;
  logic [7:0] hold_d;
  logic hold_l;

  // clock / reset
  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    i_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: everything sampled on the falling edge, inputs move after the rising edge
  always @(negedge clk) begin
    if (rst) begin
      hold_v  = 0;
      prev_ok = 0;
    end else begin
      if (o_frame_ok) n_ok++;
      if (o_crc_err) n_crc++;
      if (o_len_err) n_len++;
      if (o_timeout) n_to++;
      if (prev_ok && !o_valid) lat_viol++;
      if (hold_v && (!o_valid || o_data !== hold_d || o_last !== hold_l)) stab_viol++;
      if ((o_state == DRAIN || o_valid) && o_ready) rdy_viol++;
      if (o_valid && i_ready) got_q.push_back({o_last, o_data});
      hold_v  = o_valid && !i_ready;
      hold_d  = o_data;
      hold_l  = o_last;
      prev_ok = o_frame_ok;
    end
  end

  // reference model: CRC-32 as defined for the link, and the frame it implies
  function automatic logic [31:0] crc_of_payload();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (pl_q[k]) begin
      c = c ^ {24'd0, pl_q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return 0;
    foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) return k;
    return -1;
  endfunction

  // driver tasks (called on a falling edge)
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_valid = 1;
    i_data  = b;
    while (!o_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      total++; bad++;
      $display("FAIL send_byte_stall: o_ready=%0b required 1 within %0d cycles", o_ready, BUDGET);
    end else begin
      @(negedge clk);
    end
    i_valid = 0;
  endtask

  task automatic send_frame(input bit corrupt);
    logic [31:0] c = crc_of_payload();
    if (corrupt) c[24] = ~c[24];
    send_byte(SOF_BYTE);
    send_byte(8'(pl_q.size()));
    foreach (pl_q[k]) send_byte(pl_q[k]);
    for (int k = 0; k < 4; k++) send_byte(c[8*k +: 8]);
    if (!corrupt) foreach (pl_q[k]) exp_q.push_back({(k == pl_q.size() - 1), pl_q[k]});
  endtask

  task automatic load_check_frame();
    pl_q.delete();
    for (int k = 0; k < 9; k++) pl_q.push_back(8'h31 + 8'(k));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(o_state == HUNT && !o_valid) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (n >= BUDGET) begin
      bad++;
      $display("FAIL wait_idle: state=%0d valid=%0b required HUNT/0", o_state, o_valid);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    i_valid = 0; i_data = 0;
    do_reset();
    total++; if (o_state !== HUNT) begin bad++; $display("FAIL reset_state: got %0d required %0d", o_state, HUNT); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", o_ready); end
    total++; if (o_valid !== 1'b0 || o_last !== 1'b0) begin bad++; $display("FAIL reset_valid_last: got %b%b required 00", o_valid, o_last); end
    total++; if ({o_frame_ok, o_crc_err, o_len_err, o_timeout} !== 4'b0) begin bad++; $display("FAIL reset_pulses: got %b required 0000", {o_frame_ok, o_crc_err, o_len_err, o_timeout}); end
  endtask

  task automatic test_known_vector();
    int b_ok = n_ok, b_crc = n_crc;
    exp_q.delete(); got_q.delete();
    load_check_frame();
    send_frame(0);
    wait_idle();
    total++; if (n_ok - b_ok != 1 || n_crc - b_crc != 0) begin bad++; $display("FAIL known_pulses: ok=%0d crc=%0d required 1 0", n_ok - b_ok, n_crc - b_crc); end
    total++; if (first_diff() >= 0) begin bad++; $display("FAIL known_payload: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
    total++; if (lat_viol != 0) begin bad++; $display("FAIL known_latency: violations=%0d required 0", lat_viol); end
  endtask

  task automatic test_crc_err();
    int b_ok = n_ok, b_crc = n_crc;
    exp_q.delete(); got_q.delete();
    load_check_frame();
    send_frame(1);
    wait_idle();
    total++; if (n_crc - b_crc != 1 || n_ok - b_ok != 0) begin bad++; $display("FAIL crc_err_pulses: crc=%0d ok=%0d required 1 0", n_crc - b_crc, n_ok - b_ok); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL crc_err_output: got %0d bytes required 0", got_q.size()); end
    send_frame(0);
    wait_idle();
    total++; if (n_ok - b_ok != 1 || first_diff() >= 0) begin bad++; $display("FAIL crc_err_recover: ok=%0d bytes=%0d required 1 %0d", n_ok - b_ok, got_q.size(), exp_q.size()); end
  endtask

  task automatic test_len_err();
    int b_len = n_len, b_ok = n_ok;
    exp_q.delete(); got_q.delete();
    send_byte(SOF_BYTE); send_byte(8'h00);
    @(negedge clk);
    total++; if (o_state !== HUNT || n_len - b_len != 1) begin bad++; $display("FAIL len_zero: state=%0d len_err=%0d required HUNT 1", o_state, n_len - b_len); end
    send_byte(SOF_BYTE); send_byte(8'(MAX_LEN + 1));
    @(negedge clk);
    total++; if (o_state !== HUNT || n_len - b_len != 2) begin bad++; $display("FAIL len_over: state=%0d len_err=%0d required HUNT 2", o_state, n_len - b_len); end
    pl_q.delete();
    for (int k = 0; k < MAX_LEN; k++) pl_q.push_back(8'($urandom));
    send_frame(0);
    wait_idle();
    total++; if (n_ok - b_ok != 1 || first_diff() >= 0) begin bad++; $display("FAIL len_max_frame: ok=%0d bytes=%0d required 1 %0d", n_ok - b_ok, got_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int b_ok = n_ok;
    exp_q.delete(); got_q.delete();
    stab_viol = 0; rdy_viol = 0;
    rnd_ready = 1;
    load_check_frame();
    send_frame(0);
    wait_idle();
    rnd_ready = 0;
    total++; if (n_ok - b_ok != 1 || first_diff() >= 0) begin bad++; $display("FAIL bp_payload: ok=%0d bytes=%0d required 1 %0d", n_ok - b_ok, got_q.size(), exp_q.size()); end
    total++; if (stab_viol != 0) begin bad++; $display("FAIL bp_stable: violations=%0d required 0", stab_viol); end
    total++; if (rdy_viol != 0) begin bad++; $display("FAIL bp_ready_low: violations=%0d required 0", rdy_viol); end
  endtask

  task automatic test_back_to_back();
    int b_ok = n_ok;
    exp_q.delete(); got_q.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    load_check_frame();
    send_frame(0);
    pl_q.delete();
    pl_q.push_back(SOF_BYTE);
    send_frame(0);
    wait_idle();
    total++; if (n_ok - b_ok != 2) begin bad++; $display("FAIL b2b_frames: ok=%0d required 2", n_ok - b_ok); end
    total++; if (first_diff() >= 0) begin bad++; $display("FAIL b2b_payload: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int b_ok, b_crc, b_len, b_to;
    exp_q.delete(); got_q.delete();
    send_byte(SOF_BYTE); send_byte(8'd5);
    send_byte(8'h11); send_byte(8'h22);
    b_ok = n_ok; b_crc = n_crc; b_len = n_len; b_to = n_to;
    do_reset();
    repeat (3) @(negedge clk);
    total++; if (o_state !== HUNT || n_ok + n_crc + n_len + n_to != b_ok + b_crc + b_len + b_to) begin bad++; $display("FAIL rst_mid: state=%0d extra_pulses=%0d required HUNT 0", o_state, n_ok + n_crc + n_len + n_to - b_ok - b_crc - b_len - b_to); end
    load_check_frame();
    send_frame(0);
    wait_idle();
    total++; if (n_ok - b_ok != 1 || first_diff() >= 0) begin bad++; $display("FAIL rst_mid_recover: ok=%0d bytes=%0d required 1 %0d", n_ok - b_ok, got_q.size(), exp_q.size()); end
  endtask

`ifdef PKT_RX_TIMEOUT_EN
  task automatic test_timeout();
    int b_to = n_to, b_ok = n_ok;
    exp_q.delete(); got_q.delete();
    send_byte(SOF_BYTE); send_byte(8'd9);
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    repeat (TO + 5) @(negedge clk);
    total++; if (n_to - b_to != 1 || o_state !== HUNT) begin bad++; $display("FAIL timeout: pulses=%0d state=%0d required 1 HUNT", n_to - b_to, o_state); end
    load_check_frame();
    send_frame(0);
    wait_idle();
    total++; if (n_ok - b_ok != 1 || first_diff() >= 0) begin bad++; $display("FAIL timeout_recover: ok=%0d bytes=%0d required 1 %0d", n_ok - b_ok, got_q.size(), exp_q.size()); end
  endtask
`endif

  task automatic test_random();
    int b_ok = n_ok, b_crc = n_crc, b_to = n_to;
    int e_ok = 0, e_crc = 0;
    bit corrupt;
    int len;
    exp_q.delete(); got_q.delete();
    stab_viol = 0; lat_viol = 0;
    rnd_ready = 1;
    for (int f = 0; f < 10; f++) begin
      len = (f == 0) ? 1 : (f == 1) ? MAX_LEN : $urandom_range(1, MAX_LEN);
      pl_q.delete();
      for (int k = 0; k < len; k++) pl_q.push_back(8'($urandom));
      corrupt = ($urandom_range(0, 3) == 0);
      if (corrupt) e_crc++; else e_ok++;
      send_frame(corrupt);
    end
    wait_idle();
    rnd_ready = 0;
    total++; if (n_ok - b_ok != e_ok || n_crc - b_crc != e_crc) begin bad++; $display("FAIL rand_pulses: ok=%0d crc=%0d required %0d %0d", n_ok - b_ok, n_crc - b_crc, e_ok, e_crc); end
    total++; if (first_diff() >= 0) begin bad++; $display("FAIL rand_payload: got %0d bytes required %0d, first diff at %0d", got_q.size(), exp_q.size(), first_diff()); end
    total++; if (stab_viol != 0 || lat_viol != 0) begin bad++; $display("FAIL rand_timing: stable=%0d latency=%0d required 0 0", stab_viol, lat_viol); end
    total++; if (n_to - b_to != 0) begin bad++; $display("FAIL rand_no_timeout: got %0d required 0", n_to - b_to); end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_known_vector();
    test_crc_err();
    test_len_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PKT_RX_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
